// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared constants, config type and width helper for the serial pattern detector
package seq_det_pkg;

   localparam int          DEF_MAX_LEN = 8;
   localparam int          DEF_CNT_W   = 8;
   localparam logic [31:0] DEF_RST_PAT = 32'h0000_000B;
   localparam int          DEF_RST_LEN = 4;
   localparam logic        DEF_RST_OVL = 1'b1;

   typedef struct packed {
      logic [31:0] pat;
      logic [5:0]  len;
      logic        overlap;
   } cfg_t;

   function automatic int len_w(input int max_len);
      return $clog2(max_len + 1);
   endfunction

endpackage

// File: rtl/seq_detector_mealy_param_sat_counter.sv
// sat_counter: saturating event counter with a sticky all-ones flag
module sat_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] count,
   output logic             sat
);

   logic [CNT_W-1:0] nxt;

   // clear beats a coincident increment; increments stop at all-ones
   always_comb begin
      nxt = clr ? '0 : (inc && !(&count)) ? count + 1'b1 : count;
   end

   // count register; sat latches once the count lands on all-ones
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
         sat   <= 1'b0;
      end else begin
         count <= nxt;
         sat   <= clr ? 1'b0 : (sat | (&nxt));
      end
   end

endmodule

// File: rtl/seq_detector_mealy_param.sv
// seq_detector_mealy_param: programmable Mealy serial-pattern detector with saturating match counter
module seq_detector_mealy_param
   import seq_det_pkg::*;
#(
   parameter int                 MAX_LEN = DEF_MAX_LEN,
   parameter int                 CNT_W   = DEF_CNT_W,
   parameter logic [MAX_LEN-1:0] RST_PAT = DEF_RST_PAT[MAX_LEN-1:0],
   parameter int                 RST_LEN = DEF_RST_LEN,
   parameter logic               RST_OVL = DEF_RST_OVL,
   localparam int                LW      = len_w(MAX_LEN)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cfg_load,
   input  logic [MAX_LEN-1:0] cfg_pat,
   input  logic [LW-1:0]      cfg_len,
   input  logic               cfg_overlap,
   input  logic               cnt_clr,
   input  logic               in_valid,
   input  logic               x,
   output logic               z,
   output logic [CNT_W-1:0]   match_cnt,
   output logic               cnt_sat
);

   logic [MAX_LEN-1:0] pat_r;
   logic [LW-1:0]      len_r;
   logic               ovl_r;
   logic [MAX_LEN-2:0] hist;
   logic [LW-1:0]      fill;
   logic [LW-1:0]      fill_nxt;
   logic [MAX_LEN-1:0] window;
   logic [MAX_LEN:0]   mask;
   logic               legal;
   logic               hit;
   logic               fill_ok;

   // compare the newest len_r bits (history plus the live bit) against the pattern
   always_comb begin
      window   = {hist, x};
      legal    = (len_r != '0) && (len_r <= LW'(MAX_LEN));
      mask     = ((MAX_LEN + 1)'(1) << len_r) - 1'b1;
      hit      = (({1'b0, window ^ pat_r}) & mask) == '0;
      fill_ok  = ({1'b0, fill} + 1'b1) >= {1'b0, len_r};
      z        = !reset && in_valid && !cfg_load && legal && fill_ok && hit;
      fill_nxt = (z && !ovl_r) ? '0 : (fill == LW'(MAX_LEN)) ? fill : fill + 1'b1;
   end

   // config and shift history; a config load flushes history and drops the live bit
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pat_r <= RST_PAT;
         len_r <= LW'(RST_LEN);
         ovl_r <= RST_OVL;
         hist  <= '0;
         fill  <= '0;
      end else if (cfg_load) begin
         pat_r <= cfg_pat;
         len_r <= cfg_len;
         ovl_r <= cfg_overlap;
         hist  <= '0;
         fill  <= '0;
      end else if (in_valid) begin
         hist  <= window[MAX_LEN-2:0];
         fill  <= fill_nxt;
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (z),
      .clr   (cnt_clr),
      .count (match_cnt),
      .sat   (cnt_sat)
   );

endmodule

// File: tb/tb_seq_detector_mealy_param.sv
// tb_seq_detector_mealy_param: directed self-checking bench for the programmable Mealy detector
module tb_seq_detector_mealy_param;
   import seq_det_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       cfg_load;
   logic [7:0] cfg_pat;
   logic [3:0] cfg_len;
   logic       cfg_overlap;
   logic       cnt_clr;
   logic       in_valid;
   logic       x;
   logic       z;
   logic [1:0] match_cnt;
   logic       cnt_sat;
   int         tests = 0;
   int         fails = 0;

   seq_detector_mealy_param #(.MAX_LEN(8), .CNT_W(2)) dut (
      .clk         (clk),
      .reset       (reset),
      .cfg_load    (cfg_load),
      .cfg_pat     (cfg_pat),
      .cfg_len     (cfg_len),
      .cfg_overlap (cfg_overlap),
      .cnt_clr     (cnt_clr),
      .in_valid    (in_valid),
      .x           (x),
      .z           (z),
      .match_cnt   (match_cnt),
      .cnt_sat     (cnt_sat)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // bits[n-1] is sent first; ez holds the expected z for each bit in the same order
   task automatic stream(input string tag, input int n, input logic [31:0] bits, input logic [31:0] ez);
      for (int i = n - 1; i >= 0; i--) begin
         @(negedge clk);
         x = bits[i];
         in_valid = 1'b1;
         #1;
         chk($sformatf("%s[%0d]", tag, n - 1 - i), 32'(z), 32'(ez[i]));
         @(posedge clk);
         #1;
         in_valid = 1'b0;
      end
   endtask

   task automatic load(input cfg_t c);
      @(negedge clk);
      cfg_load = 1'b1;
      cfg_pat = c.pat[7:0];
      cfg_len = c.len[3:0];
      cfg_overlap = c.overlap;
      @(posedge clk);
      #1;
      cfg_load = 1'b0;
   endtask

   task automatic clear_cnt();
      @(negedge clk);
      cnt_clr = 1'b1;
      @(posedge clk);
      #1;
      cnt_clr = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      cfg_load = 1'b0;
      cfg_pat = '0;
      cfg_len = '0;
      cfg_overlap = 1'b0;
      cnt_clr = 1'b0;
      in_valid = 1'b1;
      x = 1'b1;
      @(negedge clk);
      #1;
      chk("rst_z", 32'(z), 32'd0);
      chk("rst_cnt", 32'(match_cnt), 32'd0);
      chk("rst_sat", 32'(cnt_sat), 32'd0);
      chk("rst_fill", 32'(dut.fill), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      in_valid = 1'b0;

      stream("ovl", 7, 32'b1011011, 32'b0001001);
      chk("ovl_cnt", 32'(match_cnt), 32'd2);

      clear_cnt();
      chk("clr_cnt", 32'(match_cnt), 32'd0);
      load(cfg_t'{pat: 32'h0B, len: 6'd4, overlap: 1'b0});
      stream("novl", 7, 32'b1011011, 32'b0001000);
      chk("novl_cnt", 32'(match_cnt), 32'd1);

      load(cfg_t'{pat: 32'h0B, len: 6'd4, overlap: 1'b1});
      stream("gap_a", 2, 32'b10, 32'b00);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         x = 1'b1;
         in_valid = 1'b0;
         #1;
         chk($sformatf("gap_idle[%0d]", i), 32'(z), 32'd0);
         @(posedge clk);
         #1;
      end
      stream("gap_b", 2, 32'b11, 32'b01);
      chk("gap_cnt", 32'(match_cnt), 32'd2);

      stream("mid", 3, 32'b101, 32'b000);
      @(negedge clk);
      reset = 1'b1;
      x = 1'b1;
      in_valid = 1'b1;
      #1;
      chk("mid_rst_z", 32'(z), 32'd0);
      chk("mid_rst_cnt", 32'(match_cnt), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      in_valid = 1'b0;
      stream("post_rst", 1, 32'b1, 32'b0);
      chk("post_rst_fill", 32'(dut.fill), 32'd1);

      load(cfg_t'{pat: 32'h01, len: 6'd1, overlap: 1'b1});
      stream("len1", 4, 32'b1101, 32'b1101);
      chk("len1_cnt", 32'(match_cnt), 32'd3);

      clear_cnt();
      load(cfg_t'{pat: 32'hA5, len: 6'd8, overlap: 1'b1});
      stream("len8", 8, 32'b10100101, 32'b00000001);
      chk("len8_cnt", 32'(match_cnt), 32'd1);

      load(cfg_t'{pat: 32'h00, len: 6'd0, overlap: 1'b1});
      stream("len0", 4, 32'b0000, 32'b0000);

      load(cfg_t'{pat: 32'h01, len: 6'd1, overlap: 1'b1});
      stream("coll_pre", 1, 32'b1, 32'b1);
      @(negedge clk);
      cfg_load = 1'b1;
      cfg_pat = 8'h01;
      cfg_len = 4'd1;
      cfg_overlap = 1'b1;
      in_valid = 1'b1;
      x = 1'b1;
      #1;
      chk("coll_z", 32'(z), 32'd0);
      @(posedge clk);
      #1;
      cfg_load = 1'b0;
      in_valid = 1'b0;
      chk("coll_fill", 32'(dut.fill), 32'd0);
      chk("coll_hist", 32'(dut.hist), 32'd0);
      chk("coll_cnt", 32'(match_cnt), 32'd2);

      clear_cnt();
      stream("sat_a", 2, 32'b11, 32'b11);
      chk("sat_cnt2", 32'(match_cnt), 32'd2);
      chk("sat_flag2", 32'(cnt_sat), 32'd0);
      stream("sat_b", 1, 32'b1, 32'b1);
      chk("sat_cnt3", 32'(match_cnt), 32'd3);
      chk("sat_flag3", 32'(cnt_sat), 32'd1);
      stream("sat_c", 1, 32'b1, 32'b1);
      chk("sat_cnt4", 32'(match_cnt), 32'd3);
      chk("sat_flag4", 32'(cnt_sat), 32'd1);
      @(negedge clk);
      cnt_clr = 1'b1;
      in_valid = 1'b1;
      x = 1'b1;
      #1;
      chk("clr_hit_z", 32'(z), 32'd1);
      @(posedge clk);
      #1;
      cnt_clr = 1'b0;
      in_valid = 1'b0;
      chk("clr_hit_cnt", 32'(match_cnt), 32'd0);
      chk("clr_hit_sat", 32'(cnt_sat), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
